// File: rtl/ps2_key_filter.sv
// ps2_key_filter
// Scan-code filter and key buffer between the PS/2 byte receiver and the
// keyboard write port of data memory. Raw set-2 bytes are parsed into
// make/break events (E0 = extended prefix, F0 = break prefix), typematic
// repeats of the currently held key are dropped, and accepted keys are queued
// in a small FIFO. One memory write is issued per key, and the next write is
// held back until software acknowledges the previous key.
//
// Ports:
//   clk        system clock (byte strobes are already synchronous to it)
//   rstin      asynchronous active-low reset
//   code_valid one-cycle strobe, code_byte holds a received byte
//   code_byte  raw scan byte
//   key_ack    one-cycle pulse: the last written key has been consumed
//   we_kb      one-cycle write strobe to data memory
//   addr_kb    constant KB_ADDR
//   data_kb    {23'd0, ext, code}, held stable until the next write
//   fifo_count entries currently buffered
//   overflow   sticky flag: a key was dropped because the FIFO was full
module ps2_key_filter #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] KB_ADDR = 32'd10
) (
  input  logic                     clk,
  input  logic                     rstin,
  input  logic                     code_valid,
  input  logic [7:0]               code_byte,
  input  logic                     key_ack,
  output logic                     we_kb,
  output logic [31:0]              addr_kb,
  output logic [31:0]              data_kb,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    P_IDLE,
    P_EXT,
    P_BRK,
    P_EXT_BRK
  } p_state_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_WRITE,
    O_WAIT
  } o_state_t;

  p_state_t p_state;
  p_state_t p_next;
  o_state_t o_state;
  o_state_t o_next;

  logic       make_ev;
  logic       brk_ev;
  logic       ev_ext;
  logic       is_noise;
  logic [8:0] key;

  logic [8:0] held;
  logic       held_v;
  logic       held_match;
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic       is_full;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Keyboard self-test / protocol replies that carry no key information.
  assign is_noise = (code_byte == 8'hAA) || (code_byte == 8'hFA) ||
                    (code_byte == 8'hFE) || (code_byte == 8'hEE) ||
                    (code_byte == 8'h00) || (code_byte == 8'hFF);

  // Parser state register.
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      p_state <= P_IDLE;
    end else begin
      p_state <= p_next;
    end
  end

  // Parser next state and event decode. A break prefix seeing E0 resyncs to
  // the extended state rather than producing a bogus break of code E0.
  always_comb begin
    p_next  = p_state;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_ext  = 1'b0;
    if (code_valid) begin
      case (p_state)
        P_IDLE: begin
          if (code_byte == 8'hE0) begin
            p_next = P_EXT;
          end else if (code_byte == 8'hF0) begin
            p_next = P_BRK;
          end else if (!is_noise) begin
            make_ev = 1'b1;
          end
        end
        P_EXT: begin
          if (code_byte == 8'hF0) begin
            p_next = P_EXT_BRK;
          end else if (code_byte != 8'hE0) begin
            make_ev = 1'b1;
            ev_ext  = 1'b1;
            p_next  = P_IDLE;
          end
        end
        P_BRK: begin
          if (code_byte == 8'hE0) begin
            p_next = P_EXT;
          end else if (code_byte != 8'hF0) begin
            brk_ev = 1'b1;
            p_next = P_IDLE;
          end
        end
        P_EXT_BRK: begin
          brk_ev = 1'b1;
          ev_ext = 1'b1;
          p_next = P_IDLE;
        end
        default: p_next = P_IDLE;
      endcase
    end
  end

  assign key        = {ev_ext, code_byte};
  assign held_match = held_v && (held == key);
  assign push_req   = make_ev && !held_match;

  // Held-key tracking. A make of the held key is a typematic repeat; the
  // held key is updated even if the push is later lost to a full FIFO.
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      held   <= 9'd0;
      held_v <= 1'b0;
    end else if (push_req) begin
      held   <= key;
      held_v <= 1'b1;
    end else if (brk_ev && held_match) begin
      held_v <= 1'b0;
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      o_state <= O_IDLE;
    end else begin
      o_state <= o_next;
    end
  end

  // Output FSM: pop in O_IDLE, strobe in O_WRITE, then wait for the ack.
  always_comb begin
    o_next = o_state;
    pop    = 1'b0;
    case (o_state)
      O_IDLE: begin
        if (count != '0) begin
          pop    = 1'b1;
          o_next = O_WRITE;
        end
      end
      O_WRITE: o_next = O_WAIT;
      O_WAIT: begin
        if (key_ack) begin
          o_next = O_IDLE;
        end
      end
      default: o_next = O_IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign is_full = (count == FULL_COUNT);
  assign push_ok = push_req && (!is_full || pop);

  // FIFO storage; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= key;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and the write data register.
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      data_kb  <= 32'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        data_kb <= {23'd0, mem[rd_ptr]};
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  assign we_kb      = (o_state == O_WRITE);
  assign addr_kb    = KB_ADDR;
  assign fifo_count = count;

endmodule
